uart_rx_parser: RTL
===================

UART_RX_PARSER -- requirements
Module: uart_rx_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5_000_000: idle cycles allowed between bytes inside a packet.
REQ-002 Parameter START_CHAR, default 8'h4C ('L'): packet start byte.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 received  input  1  one-cycle pulse from the upstream uart; rx_byte valid.
REQ-006 rx_byte  input  8  byte from the upstream uart.
REQ-007 rx_error  input  1  one-cycle framing-error pulse from the upstream uart.
REQ-008 master_ready  input  1  wishbone master handler can accept a command.
REQ-009 ih_ready  output  1  one-cycle pulse; in_command/in_address/in_data valid.
REQ-010 in_command  output  32  decoded command word.
REQ-011 in_address  output  32  decoded address word.
REQ-012 in_data  output  32  decoded data word.
REQ-013 parse_error  output  1  one-cycle pulse on any packet abort.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Packet format: START_CHAR, then 24 ASCII hex digits, MSB-first: 8 command, 8 address, 8 data.
REQ-016 Accepted hex digits: '0'-'9', 'A'-'F', 'a'-'f'; case-insensitive.
REQ-017 States: IDLE, READ_COMMAND, READ_ADDRESS, READ_DATA, WAIT_MASTER.
REQ-018 IDLE: received with rx_byte==START_CHAR -> READ_COMMAND and clear the nibble counter. Other bytes, including CR and LF, are ignored silently.
REQ-019 READ_* states: each valid digit shifts into the active 32-bit word (word <= {word[27:0], nibble}) and increments a 3-bit nibble counter.
REQ-020 On the 8th digit of a word, the counter wraps to 0 and the state advances: COMMAND -> ADDRESS -> DATA -> WAIT_MASTER.
REQ-021 Invalid digit in READ_* -> IDLE, parse_error pulse; no ih_ready.
REQ-022 START_CHAR received mid-packet counts as invalid (REQ-021); it does not restart the packet.
REQ-023 rx_error in any non-IDLE state -> IDLE, parse_error pulse. rx_error in IDLE is ignored.
REQ-024 rx_error and received in the same cycle: rx_error takes priority and the byte is discarded.
REQ-025 Timeout counter clears on entry to READ_COMMAND and on every received byte, and increments each cycle in READ_*.
REQ-026 Timeout counter reaching TIMEOUT_CYCLES -> IDLE, parse_error pulse.
REQ-027 WAIT_MASTER: in the first cycle with master_ready high, ih_ready pulses for exactly one cycle, then IDLE.
REQ-028 Latency: if master_ready is already high, ih_ready asserts the cycle after the cycle in which the 24th digit's received is sampled.
REQ-029 received in WAIT_MASTER: byte discarded, parse_error pulses, state stays WAIT_MASTER and the words are preserved.
REQ-030 in_command/in_address/in_data hold their values from the last ih_ready until the next ih_ready.
REQ-031 The shift registers are internal; the output words update only together, in the cycle ih_ready asserts.
REQ-032 ih_ready and parse_error are never high in the same cycle.

Reset
REQ-033 rst high at a clock edge -> state IDLE; nibble counter, timeout counter, shift registers and all outputs = 0.
REQ-034 rst high mid-packet discards the partial packet without pulsing parse_error.
REQ-035 rst high in WAIT_MASTER: ih_ready does not assert.

Structure
REQ-036 A shared defines file holds the state encodings, the START_CHAR default and the 24-bit timeout width constant.
REQ-037 Hex decoding is one combinational sub-module, ascii_hex_decode: inputs byte[7:0]; outputs nibble[3:0] and valid.
REQ-038 Target size is 120-400 lines of RTL; no FIFO; one packet in flight.

Verification
REQ-039 "L00000001000000100000ABCD" with master_ready=1 -> one ih_ready; in_command=32'h1, in_address=32'h10, in_data=32'hABCD; parse_error never asserts.
REQ-040 Same packet with master_ready=0 for 50 cycles after the last byte -> busy=1, no ih_ready. Raise master_ready -> ih_ready exactly one cycle later, same values.
REQ-041 "L0000G..." -> parse_error pulse on 'G', state IDLE. A following valid packet with lowercase "abcdef01" data -> in_data=32'hABCDEF01.
REQ-042 TIMEOUT_CYCLES=100; send "L1234" then silence -> parse_error exactly 100 cycles after the last received pulse, busy=0.
REQ-043 rx_error coincident with received during READ_ADDRESS -> parse_error, IDLE, outputs still hold the prior packet values.
REQ-044 rst asserted after 10 digits -> no parse_error, busy=0; the next valid packet decodes correctly.

Source files
------------

// File: rtl/uart_rx_parser_pkg.sv
// uart_rx_parser_pkg: shared state encodings and constants for the packet parser
package uart_rx_parser_pkg;
  localparam int TIMEOUT_W = 24;
  localparam logic [7:0] START_CHAR_DEFAULT = 8'h4C;
  typedef enum logic [2:0] {
    IDLE,
    READ_COMMAND,
    READ_ADDRESS,
    READ_DATA,
    WAIT_MASTER
  } state_t;
endpackage

// File: rtl/uart_rx_parser_ascii_hex_decode.sv
// ascii_hex_decode: maps an ASCII hex digit (either case) to its 4-bit value
module ascii_hex_decode (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       valid
);
  logic [7:0] lower;
  logic       digit;
  logic       alpha;
  assign lower  = ascii | 8'h20;
  assign digit  = ascii >= 8'h30 && ascii <= 8'h39;
  assign alpha  = lower >= 8'h61 && lower <= 8'h66;
  assign valid  = digit | alpha;
  assign nibble = digit ? ascii[3:0] : alpha ? ascii[3:0] + 4'd9 : 4'd0;
endmodule

// File: rtl/uart_rx_parser.sv
// uart_rx_parser: assembles hex-encoded command packets from a uart byte stream
module uart_rx_parser
  import uart_rx_parser_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter logic [7:0]           START_CHAR     = START_CHAR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  input  logic        master_ready,
  output logic        ih_ready,
  output logic [31:0] in_command,
  output logic [31:0] in_address,
  output logic [31:0] in_data,
  output logic        parse_error,
  output logic        busy
);
  state_t               state, state_n;
  logic [2:0]           cnt, cnt_n;
  logic [TIMEOUT_W-1:0] timer;
  logic [31:0]          cmd_sr, addr_sr, data_sr;
  logic [31:0]          cmd_n, addr_n, data_n;
  logic [3:0]           nib;
  logic                 digit_ok;
  logic                 reading;
  logic                 timeout;
  logic                 last;
  logic                 abort;
  logic                 fire;

  ascii_hex_decode u_dec (
    .ascii  (rx_byte),
    .nibble (nib),
    .valid  (digit_ok)
  );

  assign reading     = state inside {READ_COMMAND, READ_ADDRESS, READ_DATA};
  assign timeout     = reading && !received && timer == TIMEOUT_CYCLES - 1'b1;
  assign last        = cnt == 3'd7;
  assign busy        = state != IDLE;
  assign parse_error = abort && !rst;

  // next state, shifted words, and the abort/complete decisions for this cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd_sr;
    addr_n  = addr_sr;
    data_n  = data_sr;
    abort   = 1'b0;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (received && !rx_error && rx_byte == START_CHAR) begin
          state_n = READ_COMMAND;
          cnt_n   = 3'd0;
        end
      end
      READ_COMMAND, READ_ADDRESS, READ_DATA: begin
        abort = rx_error || timeout || (received && !digit_ok);
        if (abort) state_n = IDLE;
        else if (received) begin
          cnt_n  = cnt + 3'd1;
          cmd_n  = state == READ_COMMAND ? {cmd_sr[27:0], nib} : cmd_sr;
          addr_n = state == READ_ADDRESS ? {addr_sr[27:0], nib} : addr_sr;
          data_n = state == READ_DATA ? {data_sr[27:0], nib} : data_sr;
          fire   = last && state == READ_DATA && master_ready;
          if (last) state_n = state == READ_COMMAND ? READ_ADDRESS :
                              state == READ_ADDRESS ? READ_DATA :
                              fire ? IDLE : WAIT_MASTER;
        end
      end
      WAIT_MASTER: begin
        abort   = rx_error || received;
        fire    = !abort && master_ready;
        state_n = (rx_error || fire) ? IDLE : WAIT_MASTER;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, counters, shift registers and the registered handoff to the master
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      timer      <= '0;
      cmd_sr     <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      ih_ready   <= 1'b0;
      in_command <= '0;
      in_address <= '0;
      in_data    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      timer    <= (received || !reading) ? '0 : timer + 1'b1;
      cmd_sr   <= cmd_n;
      addr_sr  <= addr_n;
      data_sr  <= data_n;
      ih_ready <= fire;
      if (fire) begin
        in_command <= cmd_n;
        in_address <= addr_n;
        in_data    <= data_n;
      end
    end
  end
endmodule
